sram_scan_sequencer: RTL and testbench

- On-chip hardware sequencer for the 112-bit SRAM test scan chain.
- Accepts one parallel command: packet plus op (write/read).
- Drives the chain control pins (scan_in, scan_en, sram_load, global csb) in the fixed order the chain needs.
- For reads, unloads the chain and returns the captured packet, optionally compared against the expected packet.
- Sits between the logic-analyzer/Wishbone command registers and the existing scan chain/SRAM-select datapath, and replaces the external GPIO bit-banging.

---
 rtl/sram_scan_pkg.sv | 57 +++++
 rtl/sram_scan_shifter.sv | 52 +++++
 rtl/sram_scan_sequencer.sv | 173 +++++++++++++++++
 tb/tb_sram_scan_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_scan_pkg.sv
// Shared definitions for the SRAM test scan-chain sequencer.
// Holds the chain length, the sequencer state encoding, the packet field
// layout (MSB to LSB: sel, addr0, din0, csb0, web0, wmask0, addr1, din1,
// csb1, web1, wmask1) and a helper that assembles a packet from its fields.
package sram_scan_pkg;

    localparam int CHAIN_LEN = 112;
    localparam int CNT_W     = $clog2(CHAIN_LEN);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_IN,
        EXEC,
        CAPTURE,
        LOAD,
        SHIFT_OUT,
        RESP
    } state_t;

    // Packet field positions
    localparam int SEL_MSB    = 111;
    localparam int SEL_LSB    = 108;
    localparam int ADDR0_MSB  = 107;
    localparam int ADDR0_LSB  = 92;
    localparam int DIN0_MSB   = 91;
    localparam int DIN0_LSB   = 60;
    localparam int CSB0_BIT   = 59;
    localparam int WEB0_BIT   = 58;
    localparam int WMASK0_MSB = 57;
    localparam int WMASK0_LSB = 54;
    localparam int ADDR1_MSB  = 53;
    localparam int ADDR1_LSB  = 38;
    localparam int DIN1_MSB   = 37;
    localparam int DIN1_LSB   = 6;
    localparam int CSB1_BIT   = 5;
    localparam int WEB1_BIT   = 4;
    localparam int WMASK1_MSB = 3;
    localparam int WMASK1_LSB = 0;

    function automatic logic [CHAIN_LEN-1:0] pack_packet(
        input logic [3:0]  sel,
        input logic [15:0] addr0,
        input logic [31:0] din0,
        input logic        csb0,
        input logic        web0,
        input logic [3:0]  wmask0,
        input logic [15:0] addr1,
        input logic [31:0] din1,
        input logic        csb1,
        input logic        web1,
        input logic [3:0]  wmask1
    );
        return {sel, addr0, din0, csb0, web0, wmask0,
                addr1, din1, csb1, web1, wmask1};
    endfunction

endpackage

// File: rtl/sram_scan_shifter.sv
// CHAIN_LEN-bit shift register with parallel load, serial in on the LSB,
// and a bit counter with terminal-count flag.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   load         parallel load of load_data (has priority over shift)
//   load_data    parallel data
//   shift        shift left one bit, serial_in enters at bit 0
//   serial_in    serial input bit
//   cnt_clr      clear the bit counter (priority over counting)
//   shifted      value the register takes on a shift: {data[MSB-1:0], serial_in}
//   tc           counter is at CHAIN_LEN-1
module sram_scan_shifter
    import sram_scan_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [CHAIN_LEN-1:0] load_data,
    input  logic                 shift,
    input  logic                 serial_in,
    input  logic                 cnt_clr,
    output logic [CHAIN_LEN-1:0] shifted,
    output logic                 tc
);

    logic [CHAIN_LEN-1:0] data;
    logic [CNT_W-1:0]     count;

    assign shifted = {data[CHAIN_LEN-2:0], serial_in};
    assign tc      = (count == CNT_W'(CHAIN_LEN - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            data  <= '0;
            count <= '0;
        end else begin
            if (load) begin
                data <= load_data;
            end else if (shift) begin
                data <= shifted;
            end

            // Counter saturates at the terminal count; it never wraps.
            if (cnt_clr) begin
                count <= '0;
            end else if (shift && !tc) begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_scan_sequencer.sv
// Hardware sequencer for the 112-bit SRAM test scan chain. Takes one
// parallel command, shifts the packet into the chain MSB first, pulses the
// global chip select, and for reads captures, loads and unloads the chain and
// returns the packet with an optional compare against the command packet.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready             command handshake (ready only in IDLE)
//   cmd_read, cmd_check, cmd_packet command op, compare enable, packet
//   resp_valid/resp_ready           read result handshake
//   resp_packet, resp_mismatch      unloaded packet, compare result
//   scan_in, scan_en, sram_load     chain control pins
//   sram_csb                        global SRAM chip select, active low
//   scan_out                        serial data returned by the chain
//   busy                            sequencer not in IDLE
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for a command, cmd_ready=1
// SHIFT_IN  | CHAIN_LEN cycles, scan_en=1, packet driven MSB first
// EXEC      | one cycle, sram_csb=0, SRAM access
// CAPTURE   | one cycle, sram_csb=1, dout flops capture (reads only)
// LOAD      | one cycle, sram_load=1, dout flops copied into chain
// SHIFT_OUT | CHAIN_LEN cycles, scan_en=1, scan_out sampled each cycle
// RESP      | resp_valid=1 until resp_ready
module sram_scan_sequencer
    import sram_scan_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_read,
    input  logic                 cmd_check,
    input  logic [CHAIN_LEN-1:0] cmd_packet,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [CHAIN_LEN-1:0] resp_packet,
    output logic                 resp_mismatch,
    output logic                 scan_in,
    output logic                 scan_en,
    output logic                 sram_load,
    output logic                 sram_csb,
    input  logic                 scan_out,
    output logic                 busy
);

    state_t               state;
    logic                 op_read;
    logic                 op_check;
    logic [CHAIN_LEN-1:0] expected;

    logic                 sh_load;
    logic                 sh_shift;
    logic                 sh_serial_in;
    logic                 sh_cnt_clr;
    logic [CHAIN_LEN-1:0] sh_shifted;
    logic                 sh_tc;

    // Shifter control decoded from the current state. Holding the counter
    // clear outside an active shift clears it on every state entry.
    always_comb begin
        sh_load      = (state == IDLE) && cmd_valid;
        sh_shift     = (state == SHIFT_IN) || (state == SHIFT_OUT);
        sh_serial_in = (state == SHIFT_OUT) ? scan_out : 1'b0;
        sh_cnt_clr   = !(sh_shift && !sh_tc);
    end

    sram_scan_shifter u_shifter (
        .clk       (clk),
        .reset     (reset),
        .load      (sh_load),
        .load_data (cmd_packet),
        .shift     (sh_shift),
        .serial_in (sh_serial_in),
        .cnt_clr   (sh_cnt_clr),
        .shifted   (sh_shifted),
        .tc        (sh_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            op_read       <= 1'b0;
            op_check      <= 1'b0;
            expected      <= '0;
            cmd_ready     <= 1'b1;
            busy          <= 1'b0;
            resp_valid    <= 1'b0;
            resp_packet   <= '0;
            resp_mismatch <= 1'b0;
            scan_in       <= 1'b0;
            scan_en       <= 1'b0;
            sram_load     <= 1'b0;
            sram_csb      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        expected  <= cmd_packet;
                        op_read   <= cmd_read;
                        op_check  <= cmd_check;
                        // First serial bit is presented together with scan_en.
                        scan_in   <= cmd_packet[CHAIN_LEN-1];
                        scan_en   <= 1'b1;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SHIFT_IN;
                    end
                end

                SHIFT_IN: begin
                    if (sh_tc) begin
                        scan_en  <= 1'b0;
                        scan_in  <= 1'b0;
                        sram_csb <= 1'b0;
                        state    <= EXEC;
                    end else begin
                        // Top bit after this edge's shift is the next to send.
                        scan_in <= sh_shifted[CHAIN_LEN-1];
                    end
                end

                EXEC: begin
                    sram_csb <= 1'b1;
                    if (op_read) begin
                        state <= CAPTURE;
                    end else begin
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end

                CAPTURE: begin
                    sram_load <= 1'b1;
                    state     <= LOAD;
                end

                LOAD: begin
                    sram_load <= 1'b0;
                    scan_en   <= 1'b1;
                    state     <= SHIFT_OUT;
                end

                SHIFT_OUT: begin
                    if (sh_tc) begin
                        // sh_shifted already includes the final scan_out bit.
                        scan_en       <= 1'b0;
                        resp_valid    <= 1'b1;
                        resp_packet   <= sh_shifted;
                        resp_mismatch <= op_check && (sh_shifted != expected);
                        state         <= RESP;
                    end
                end

                RESP: begin
                    if (resp_ready) begin
                        resp_valid    <= 1'b0;
                        resp_mismatch <= 1'b0;
                        busy          <= 1'b0;
                        cmd_ready     <= 1'b1;
                        state         <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_scan_sequencer.sv
module tb_sram_scan_sequencer;
    import sram_scan_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_read;
    logic                 cmd_check;
    logic [CHAIN_LEN-1:0] cmd_packet;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [CHAIN_LEN-1:0] resp_packet;
    logic                 resp_mismatch;
    logic                 scan_in;
    logic                 scan_en;
    logic                 sram_load;
    logic                 sram_csb;
    logic                 scan_out;
    logic                 busy;

    always #5 clk = ~clk;

    sram_scan_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_read      (cmd_read),
        .cmd_check     (cmd_check),
        .cmd_packet    (cmd_packet),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_packet   (resp_packet),
        .resp_mismatch (resp_mismatch),
        .scan_in       (scan_in),
        .scan_en       (scan_en),
        .sram_load     (sram_load),
        .sram_csb      (sram_csb),
        .scan_out      (scan_out),
        .busy          (busy)
    );

    // Scan chain model: shifts toward the MSB, scan_out is the MSB, and a
    // load pulse replaces its contents with what the SRAM returns.
    logic [CHAIN_LEN-1:0] chain = '0;
    logic [CHAIN_LEN-1:0] load_val = '0;
    assign scan_out = chain[CHAIN_LEN-1];

    always @(posedge clk) begin
        if (sram_load)    chain <= load_val;
        else if (scan_en) chain <= {chain[CHAIN_LEN-2:0], scan_in};
    end

    // Protocol monitor: cumulative counts, read as differences by the test.
    int                   viol_cnt = 0;
    int                   load_cnt = 0;
    int                   csb_cnt  = 0;
    int                   rv_cnt   = 0;
    logic [CHAIN_LEN-1:0] exec_snap = '0;

    always @(negedge clk) begin
        if (!reset) begin
            if (sram_load && scan_en) viol_cnt++;
            if (!sram_csb && (scan_en || sram_load)) viol_cnt++;
            if (sram_load) load_cnt++;
            if (!sram_csb) begin
                csb_cnt++;
                exec_snap = chain;
            end
            if (resp_valid) rv_cnt++;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [CHAIN_LEN-1:0] act,
                       input logic [CHAIN_LEN-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        logic                 rd;
        logic                 chk;
        logic [CHAIN_LEN-1:0] pkt;
        logic [CHAIN_LEN-1:0] ret;
        int                   bp;
        int                   exp_busy;
        logic                 exp_mm;
        logic [CHAIN_LEN-1:0] exp_resp;
    } vec_t;

    // Reference model: outcome of one command from the operation rules.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        r.exp_busy = v.rd ? (2 * CHAIN_LEN + 3) : (CHAIN_LEN + 1);
        r.exp_mm   = v.rd && v.chk && (v.ret != v.pkt);
        r.exp_resp = v.ret;
        return r;
    endfunction

    function automatic logic [CHAIN_LEN-1:0] rand_pkt();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[CHAIN_LEN-1:0];
    endfunction

    task automatic run_op(input int id, input vec_t v);
        int   n;
        int   base_load, base_csb, base_rv;
        logic stable;
        @(negedge clk);
        load_val   = v.ret;
        resp_ready = (v.bp == 0);
        cmd_valid  = 1'b1;
        cmd_read   = v.rd;
        cmd_check  = v.chk;
        cmd_packet = v.pkt;
        chk($sformatf("v%0d.ready_idle", id), cmd_ready, 1'b1);
        @(posedge clk);
        base_load = load_cnt;
        base_csb  = csb_cnt;
        base_rv   = rv_cnt;
        @(negedge clk);
        // Scramble inputs after accept; they must have no effect.
        cmd_valid  = 1'b0;
        cmd_packet = ~v.pkt;
        cmd_read   = ~v.rd;
        cmd_check  = ~v.chk;
        chk($sformatf("v%0d.ready_low", id), cmd_ready, 1'b0);
        n = 0;
        if (!v.rd) begin
            while (busy && n < 400) begin
                n++;
                @(negedge clk);
            end
            chk($sformatf("v%0d.busy_cycles", id), n, v.exp_busy);
            chk($sformatf("v%0d.no_resp", id), rv_cnt - base_rv, 0);
            chk($sformatf("v%0d.ready_back", id), cmd_ready, 1'b1);
        end else begin
            while (!resp_valid && n < 400) begin
                n++;
                @(negedge clk);
            end
            chk($sformatf("v%0d.busy_cycles", id), n, v.exp_busy);
            chk($sformatf("v%0d.resp_packet", id), resp_packet, v.exp_resp);
            chk($sformatf("v%0d.mismatch", id), resp_mismatch, v.exp_mm);
            if (v.bp > 0) begin
                stable = 1'b1;
                for (int i = 0; i < v.bp; i++) begin
                    cmd_valid  = 1'b1;
                    cmd_packet = rand_pkt();
                    @(negedge clk);
                    if (!(resp_valid && busy && !cmd_ready &&
                          resp_packet == v.exp_resp && resp_mismatch == v.exp_mm))
                        stable = 1'b0;
                end
                chk($sformatf("v%0d.hold_stable", id), stable, 1'b1);
                cmd_valid  = 1'b0;
                resp_ready = 1'b1;
            end
            @(negedge clk);
            chk($sformatf("v%0d.release", id), {resp_valid, busy, cmd_ready}, 3'b001);
            resp_ready = 1'b0;
        end
        chk($sformatf("v%0d.exec_chain", id), exec_snap, v.pkt);
        chk($sformatf("v%0d.csb_pulses", id), csb_cnt - base_csb, 1);
        chk($sformatf("v%0d.load_pulses", id), load_cnt - base_load, v.rd ? 1 : 0);
    endtask

    localparam int NV = 10;
    vec_t vecs[NV];

    initial begin
        logic [CHAIN_LEN-1:0] flip;
        vec_t                 w;

        // Directed vectors
        vecs[0] = '{rd: 1'b0, chk: 1'b0, bp: 0, exp_busy: 0, exp_mm: 1'b0, exp_resp: '0,
                    pkt: pack_packet(4'h0, 16'h1, 32'h0, 1'b0, 1'b0, 4'hF,
                                     16'h0, 32'h0, 1'b1, 1'b1, 4'hF),
                    ret: '0};
        vecs[1] = '{rd: 1'b1, chk: 1'b1, bp: 0, exp_busy: 0, exp_mm: 1'b0, exp_resp: '0,
                    pkt: pack_packet(4'h0, 16'h1, 32'h1, 1'b0, 1'b1, 4'hF,
                                     16'h2, 32'h8, 1'b0, 1'b1, 4'hF),
                    ret: pack_packet(4'h0, 16'h1, 32'h1, 1'b0, 1'b1, 4'hF,
                                     16'h2, 32'h8, 1'b0, 1'b1, 4'hF)};
        vecs[2] = '{rd: 1'b1, chk: 1'b1, bp: 20, exp_busy: 0, exp_mm: 1'b0, exp_resp: '0,
                    pkt: pack_packet(4'h8, 16'h1, 32'hDEADBEEF, 1'b0, 1'b1, 4'hF,
                                     16'h2, 32'h0, 1'b1, 1'b1, 4'hF),
                    ret: pack_packet(4'h8, 16'h1, 32'hDEADBEEE, 1'b0, 1'b1, 4'hF,
                                     16'h2, 32'h0, 1'b1, 1'b1, 4'hF)};
        vecs[3] = vecs[2];
        vecs[3].chk = 1'b0;
        vecs[3].bp  = 1;
        // Randomized vectors
        for (int i = 4; i < NV; i++) begin
            flip = '0;
            flip[$urandom_range(0, CHAIN_LEN - 1)] = 1'b1;
            vecs[i].rd  = 1'($urandom_range(0, 1));
            vecs[i].chk = 1'($urandom_range(0, 1));
            vecs[i].pkt = rand_pkt();
            vecs[i].ret = $urandom_range(0, 1) ? vecs[i].pkt : (vecs[i].pkt ^ flip);
            vecs[i].bp  = $urandom_range(0, 3);
        end
        for (int i = 0; i < NV; i++) vecs[i] = model(vecs[i]);

        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_read   = 1'b0;
        cmd_check  = 1'b0;
        cmd_packet = '0;
        resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {scan_en, sram_load, sram_csb, scan_in, resp_valid,
                           resp_mismatch, busy, cmd_ready}, 8'b0010_0001);
        chk("reset_resp_packet", resp_packet, '0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) run_op(i, vecs[i]);

        // Reset in the middle of SHIFT_OUT (cycle 50 of the unload).
        @(negedge clk);
        load_val   = rand_pkt();
        cmd_valid  = 1'b1;
        cmd_read   = 1'b1;
        cmd_check  = 1'b1;
        cmd_packet = rand_pkt();
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (CHAIN_LEN + 3 + 50) @(negedge clk);
        chk("abort.in_shift_out", {scan_en, busy, sram_csb}, 3'b111);
        reset = 1'b1;
        @(negedge clk);
        chk("abort.ctrl", {scan_en, sram_load, sram_csb, scan_in, resp_valid,
                           resp_mismatch, busy, cmd_ready}, 8'b0010_0001);
        chk("abort.resp_packet", resp_packet, '0);
        reset = 1'b0;
        w = '{rd: 1'b0, chk: 1'b0, bp: 0, exp_busy: 0, exp_mm: 1'b0, exp_resp: '0,
              pkt: rand_pkt(), ret: '0};
        run_op(100, model(w));

        repeat (4) @(negedge clk);
        chk("protocol_overlap", viol_cnt, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
